// File: rtl/hawk_att_lkup_rd.sv
// HAWK ATT lookup front end: fetches one 64 B ATT line over AXI4 (single beat),
// decodes the addressed 64-bit entry and returns a translation response.
module hawk_att_lkup_rd #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 512,
    parameter int                ID_W     = 24,
    parameter logic [ADDR_W-1:0] ATT_BASE = '0,
    parameter int                WAY_W    = 48,
    parameter logic [3:0]        AXI_ID   = 4'h1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_att_id,
    input  logic              req_zero_blk_wr,
    input  logic              line_inval,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [3:0]        m_arid,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WAY_W-1:0]  rsp_ppa,
    output logic [1:0]        rsp_sts,
    output logic [7:0]        rsp_zpd_cnt,
    output logic              rsp_zpd_update,
    output logic              rsp_allow_access,
    output logic              rsp_err
);

    localparam int LINE_W = ID_W - 3;

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RSP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     w_idx;
    logic [LINE_W-1:0]   w_req_line;
    logic [2:0]          w_req_slot;
    logic [LINE_W-1:0]   r_tag;
    logic                r_tag_vld;
    logic [2:0]          r_slot;
    logic                r_zero;
    logic [DATA_W-1:0]   r_line_data;
    logic [ADDR_W-1:0]   r_araddr;
    logic                w_hit;
    logic                w_acc;
    logic                w_rd_done;
    logic                w_rd_err;
    logic                w_load;
    logic [DATA_W-1:0]   w_src;
    logic [2:0]          w_slot;
    logic                w_zero;
    logic [63:0]         w_entry;
    logic [7:0]          w_old_zpd;
    logic [7:0]          w_new_zpd;
    logic                w_upd;
    logic                w_unused;

    assign w_idx      = req_att_id - ID_W'(1);
    assign w_req_line = w_idx[ID_W-1:3];
    assign w_req_slot = w_idx[2:0];
    // A same-cycle invalidate must force a miss on the incoming request
    assign w_hit      = r_tag_vld && (r_tag == w_req_line) && !line_inval;
    assign w_acc      = (r_state == S_IDLE) && req_valid;
    assign w_rd_done  = (r_state == S_R) && m_rvalid;
    assign w_rd_err   = w_rd_done && m_rresp[1];
    assign w_load     = (w_acc && w_hit) || w_rd_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_state_nxt = w_hit ? S_RSP : S_AR;
            S_AR:   if (m_arready) w_state_nxt = S_R;
            S_R:    if (m_rvalid)  w_state_nxt = S_RSP;
            S_RSP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Hits decode from the cached line, fetches straight from the read beat
    always_comb begin
        w_src  = m_rdata;
        w_slot = r_slot;
        w_zero = r_zero;
        if (r_state == S_IDLE) begin
            w_src  = r_line_data;
            w_slot = w_req_slot;
            w_zero = req_zero_blk_wr;
        end
    end

    assign w_entry   = w_src[{w_slot, 6'd0} +: 64];
    assign w_old_zpd = w_entry[63:56];

    always_comb begin
        w_new_zpd = w_old_zpd;
        w_upd     = 1'b0;
        if (w_zero) begin
            w_new_zpd = (&w_old_zpd) ? w_old_zpd : w_old_zpd + 8'd1;
            w_upd     = 1'b1;
        end else if (w_old_zpd != 8'd0) begin
            w_new_zpd = 8'd0;
            w_upd     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tag            <= '0;
            r_tag_vld        <= 1'b0;
            r_slot           <= '0;
            r_zero           <= 1'b0;
            r_line_data      <= '0;
            r_araddr         <= '0;
            rsp_ppa          <= '0;
            rsp_sts          <= '0;
            rsp_zpd_cnt      <= '0;
            rsp_zpd_update   <= 1'b0;
            rsp_allow_access <= 1'b0;
            rsp_err          <= 1'b0;
        end else begin
            if (w_acc) begin
                r_tag    <= w_hit ? r_tag : r_tag;
                r_slot   <= w_req_slot;
                r_zero   <= req_zero_blk_wr;
                r_araddr <= ATT_BASE + (ADDR_W'(w_req_line) << 6);
            end
            if (w_rd_done && !m_rresp[1]) begin
                r_line_data <= m_rdata;
                r_tag       <= r_araddr_line(r_araddr);
            end
            if (line_inval || w_rd_err) r_tag_vld <= 1'b0;
            else if (w_rd_done)         r_tag_vld <= 1'b1;
            if (w_load) begin
                if (w_rd_err) begin
                    rsp_ppa          <= '0;
                    rsp_sts          <= '0;
                    rsp_zpd_cnt      <= '0;
                    rsp_zpd_update   <= 1'b0;
                    rsp_allow_access <= 1'b0;
                    rsp_err          <= 1'b1;
                end else begin
                    rsp_ppa          <= w_entry[WAY_W-1:0];
                    rsp_sts          <= w_entry[49:48];
                    rsp_zpd_cnt      <= w_new_zpd;
                    rsp_zpd_update   <= w_upd;
                    rsp_allow_access <= (w_entry[49:48] != 2'b00);
                    rsp_err          <= 1'b0;
                end
            end
        end
    end

    // Line number of an in-flight fetch, recovered from its byte address
    function automatic logic [LINE_W-1:0] r_araddr_line(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] v;
        v = (a - ATT_BASE) >> 6;
        return v[LINE_W-1:0];
    endfunction

    assign req_ready = (r_state == S_IDLE);
    assign m_arvalid = (r_state == S_AR);
    assign m_rready  = (r_state == S_R);
    assign rsp_valid = (r_state == S_RSP);
    assign m_araddr  = r_araddr;
    assign m_arlen   = 8'd0;
    assign m_arsize  = 3'b110;
    assign m_arburst = 2'b01;
    assign m_arid    = AXI_ID;

    assign w_unused = ^{m_rlast, m_rresp[0], w_entry[55:50], w_idx[2:0]};

endmodule

// File: tb/tb_hawk_att_lkup_rd.sv
// Self-checking bench for hawk_att_lkup_rd: vector table, corner sequences and
// randomized lookups against a line-level reference model.
`timescale 1ns/1ps
module tb_hawk_att_lkup_rd;

    localparam logic [63:0] BASE = 64'h1000;

    typedef struct packed {
        logic [47:0] ppa;
        logic [1:0]  sts;
        logic [7:0]  zpd;
        logic        upd;
        logic        allow;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [23:0] id;
        logic        zb;
        logic [1:0]  rr;
        logic [63:0] word;
        int          exp_nar;
        logic [63:0] exp_addr;
        rsp_t        exp;
    } vec_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid;
    logic         req_ready;
    logic [23:0]  req_att_id;
    logic         req_zero_blk_wr;
    logic         line_inval;
    logic         m_arvalid;
    logic         m_arready;
    logic [63:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic [3:0]   m_arid;
    logic         m_rvalid;
    logic         m_rready;
    logic [511:0] m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rlast;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [47:0]  rsp_ppa;
    logic [1:0]   rsp_sts;
    logic [7:0]   rsp_zpd_cnt;
    logic         rsp_zpd_update;
    logic         rsp_allow_access;
    logic         rsp_err;

    int checks = 0;
    int failures = 0;
    logic [511:0] tb_mem [int];
    bit m_vld;
    int m_tag;

    always #5 clk_i = ~clk_i;

    hawk_att_lkup_rd #(.ATT_BASE(BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_att_id(req_att_id), .req_zero_blk_wr(req_zero_blk_wr),
        .line_inval(line_inval),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ppa(rsp_ppa), .rsp_sts(rsp_sts), .rsp_zpd_cnt(rsp_zpd_cnt),
        .rsp_zpd_update(rsp_zpd_update), .rsp_allow_access(rsp_allow_access),
        .rsp_err(rsp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic int line_of(input logic [23:0] id);
        logic [23:0] idx;
        idx = id - 24'd1;
        return int'(idx >> 3);
    endfunction

    function automatic int slot_of(input logic [23:0] id);
        logic [23:0] idx;
        idx = id - 24'd1;
        return int'(idx & 24'd7);
    endfunction

    function automatic rsp_t cur_rsp();
        return {rsp_ppa, rsp_sts, rsp_zpd_cnt, rsp_zpd_update, rsp_allow_access, rsp_err};
    endfunction

    function automatic rsp_t expect_rsp(input logic [63:0] w, input logic zb, input bit err);
        rsp_t r;
        int old;
        int nw;
        r = '0;
        if (err) begin
            r.err = 1'b1;
            return r;
        end
        old = int'(w[63:56]);
        if (zb) begin
            nw = (old + 1 > 255) ? 255 : old + 1;
            r.upd = 1'b1;
        end else if (old != 0) begin
            nw = 0;
            r.upd = 1'b1;
        end else begin
            nw = old;
        end
        r.zpd = 8'(nw);
        r.ppa = w[47:0];
        r.sts = w[49:48];
        r.allow = (w[49:48] != 2'b00);
        return r;
    endfunction

    task automatic ensure_line(input int ln);
        logic [511:0] v;
        if (!tb_mem.exists(ln)) begin
            for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
            tb_mem[ln] = v;
        end
    endtask

    task automatic set_word(input logic [23:0] id, input logic [63:0] w);
        logic [511:0] v;
        ensure_line(line_of(id));
        v = tb_mem[line_of(id)];
        v[64*slot_of(id) +: 64] = w;
        tb_mem[line_of(id)] = v;
    endtask

    function automatic logic [63:0] word_of(input logic [23:0] id);
        logic [511:0] v;
        v = tb_mem[line_of(id)];
        return v[64*slot_of(id) +: 64];
    endfunction

    // Drives one lookup and acts as AXI slave and response consumer.
    task automatic run_req(input logic [23:0] id, input logic zb, input logic [1:0] rr,
                           input int ar_d, input int r_d, input int rsp_d,
                           input bit inv_req, input bit inv_r,
                           output rsp_t got, output int nar, output int lat,
                           output logic [63:0] addr, output bit ok);
        int arw, rw, rsw, acc_cyc;
        bit done, seen, pre_acc, pre_rsp, ar_pend;
        arw = ar_d; rw = r_d; rsw = rsp_d;
        done = 0; seen = 0; ar_pend = 0;
        nar = 0; lat = 0; ok = 1; acc_cyc = 0; got = '0; addr = '0;
        ensure_line(line_of(id));
        req_valid = 1'b1;
        req_att_id = id;
        req_zero_blk_wr = zb;
        line_inval = inv_req;
        for (int c = 0; c < 200 && !done; c++) begin
            pre_acc = req_valid && req_ready;
            pre_rsp = rsp_valid && rsp_ready;
            @(posedge clk_i); #1;
            line_inval = 1'b0;
            m_arready = 1'b0;
            m_rvalid = 1'b0;
            rsp_ready = 1'b0;
            if (pre_acc) begin
                req_valid = 1'b0;
                acc_cyc = c;
            end
            if (pre_rsp) begin
                done = 1;
            end else begin
                if (ar_pend && !m_arvalid) ok = 0;
                if (m_arvalid) begin
                    if (arw > 0) arw--;
                    else begin
                        m_arready = 1'b1;
                        nar++;
                        addr = m_araddr;
                    end
                end
                ar_pend = m_arvalid && !m_arready;
                if (m_rready) begin
                    if (rw > 0) rw--;
                    else begin
                        m_rvalid = 1'b1;
                        m_rdata = tb_mem[int'((addr - BASE) >> 6)];
                        m_rresp = rr;
                        m_rlast = 1'b1;
                        line_inval = inv_r;
                    end
                end
                if (rsp_valid) begin
                    if (!seen) begin
                        seen = 1;
                        lat = c - acc_cyc + 1;
                        got = cur_rsp();
                    end else if (got !== cur_rsp()) ok = 0;
                    if (req_ready) ok = 0;
                    if (rsw > 0) rsw--;
                    else rsp_ready = 1'b1;
                end
            end
        end
        if (!done) ok = 0;
    endtask

    vec_t tbl[8];

    initial begin
        #5ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t got;
        rsp_t exp;
        int nar, lat, ln, nrand;
        logic [63:0] addr;
        bit ok, bad, miss, zb, inv_req, inv_r;
        logic [1:0] rr;
        logic [23:0] id;
        logic [511:0] v;

        rst_i = 1'b1;
        req_valid = 0; req_att_id = 0; req_zero_blk_wr = 0; line_inval = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 0; m_rlast = 0;
        rsp_ready = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_rready", 64'(m_rready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_fields", 64'(cur_rsp()), 64'd0);
        chk("rst_araddr", m_araddr, 64'd0);
        chk("ar_const", {m_arlen, m_arsize, m_arburst, m_arid}, {8'd0, 3'b110, 2'b01, 4'h1});
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        tbl[0] = '{24'd1,  1'b0, 2'b00, 64'h0001_0000_0000_002A, 1, 64'h1000,
                   '{48'h2A, 2'd1, 8'h00, 1'b0, 1'b1, 1'b0}};
        tbl[1] = '{24'd10, 1'b0, 2'b00, 64'h0503_0000_0000_BEEF, 1, 64'h1040,
                   '{48'hBEEF, 2'd3, 8'h00, 1'b1, 1'b1, 1'b0}};
        tbl[2] = '{24'd12, 1'b0, 2'b00, 64'h0002_1234_5678_9ABC, 0, 64'h0,
                   '{48'h1234_5678_9ABC, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0}};
        tbl[3] = '{24'd20, 1'b1, 2'b00, 64'hFF01_0000_0000_0001, 1, 64'h1080,
                   '{48'h1, 2'd1, 8'hFF, 1'b1, 1'b1, 1'b0}};
        tbl[4] = '{24'd30, 1'b1, 2'b00, 64'h0700_0000_0000_0055, 1, 64'h10C0,
                   '{48'h55, 2'd0, 8'h08, 1'b1, 1'b0, 1'b0}};
        tbl[5] = '{24'd9,  1'b0, 2'b10, 64'h0401_0000_0000_0777, 1, 64'h1040,
                   '{48'h0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1}};
        tbl[6] = '{24'd9,  1'b0, 2'b00, 64'h0401_0000_0000_0777, 1, 64'h1040,
                   '{48'h777, 2'd1, 8'h00, 1'b1, 1'b1, 1'b0}};
        tbl[7] = '{24'd0,  1'b0, 2'b00, 64'h0000_FFFF_FFFF_FFFF, 1, 64'h8000FC0,
                   '{48'hFFFF_FFFF_FFFF, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0}};

        for (int i = 0; i < 8; i++) set_word(tbl[i].id, tbl[i].word);
        for (int i = 0; i < 8; i++) begin
            run_req(tbl[i].id, tbl[i].zb, tbl[i].rr, 0, 0, 0, 0, 0, got, nar, lat, addr, ok);
            chk($sformatf("v%0d_rsp", i), 64'(got), 64'(tbl[i].exp));
            chk($sformatf("v%0d_nar", i), 64'(nar), 64'(tbl[i].exp_nar));
            chk($sformatf("v%0d_proto", i), 64'(ok), 64'd1);
            if (tbl[i].exp_nar > 0) chk($sformatf("v%0d_addr", i), addr, tbl[i].exp_addr);
            else chk($sformatf("v%0d_hit_lat", i), 64'(lat <= 2), 64'd1);
        end

        set_word(24'd50, 64'h0301_0000_0000_0ABC);
        run_req(24'd50, 0, 2'b00, 2, 3, 5, 0, 0, got, nar, lat, addr, ok);
        chk("hold_rsp", 64'(got), 64'(expect_rsp(64'h0301_0000_0000_0ABC, 0, 0)));
        chk("hold_stable", 64'(ok), 64'd1);
        chk("hold_addr", addr, 64'h1180);
        run_req(24'd50, 0, 2'b00, 0, 0, 0, 1, 0, got, nar, lat, addr, ok);
        chk("inv_req_miss", 64'(nar), 64'd1);
        run_req(24'd50, 1, 2'b00, 0, 0, 0, 0, 0, got, nar, lat, addr, ok);
        chk("recache_hit", 64'(nar), 64'd0);
        chk("recache_rsp", 64'(got), 64'(expect_rsp(64'h0301_0000_0000_0ABC, 1, 0)));
        run_req(24'd60, 1, 2'b00, 1, 1, 0, 0, 1, got, nar, lat, addr, ok);
        chk("inv_r_rsp", 64'(got), 64'(expect_rsp(word_of(24'd60), 1, 0)));
        run_req(24'd60, 0, 2'b00, 0, 0, 0, 0, 0, got, nar, lat, addr, ok);
        chk("inv_r_refetch", 64'(nar), 64'd1);

        ensure_line(line_of(24'd70));
        req_valid = 1'b1; req_att_id = 24'd70; req_zero_blk_wr = 1'b0;
        @(posedge clk_i); #1;
        req_valid = 1'b0;
        m_arready = 1'b1;
        @(posedge clk_i); #1;
        m_arready = 1'b0;
        chk("mid_r_rready", 64'(m_rready), 64'd1);
        rst_i = 1'b1;
        #2;
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_axi", 64'({m_arvalid, m_rready, rsp_valid}), 64'd0);
        chk("mid_rst_fields", 64'(cur_rsp()), 64'd0);
        chk("mid_rst_araddr", m_araddr, 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            if (rsp_valid || m_arvalid || !req_ready) bad = 1;
        end
        chk("post_rst_quiet", 64'(bad), 64'd0);
        run_req(24'd50, 0, 2'b00, 0, 0, 0, 0, 0, got, nar, lat, addr, ok);
        chk("post_rst_miss", 64'(nar), 64'd1);
        m_vld = 1; m_tag = line_of(24'd50);

        nrand = 150;
        for (int n = 0; n < nrand; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                ln = $urandom_range(0, 4);
                for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
                for (int s = 0; s < 8; s++)
                    if ($urandom_range(0, 3) == 0) v[64*s + 56 +: 8] = 8'hFF;
                tb_mem[ln] = v;
                line_inval = 1'b1;
                @(posedge clk_i); #1;
                line_inval = 1'b0;
                m_vld = 0;
            end
            id = 24'($urandom_range(1, 40));
            zb = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            inv_req = ($urandom_range(0, 9) == 0);
            inv_r = ($urandom_range(0, 9) == 0);
            ensure_line(line_of(id));
            miss = inv_req || !(m_vld && m_tag == line_of(id));
            exp = expect_rsp(word_of(id), zb, miss && rr[1]);
            run_req(id, zb, rr, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), inv_req, inv_r, got, nar, lat, addr, ok);
            chk($sformatf("r%0d_rsp id=%0d", n, id), 64'(got), 64'(exp));
            chk($sformatf("r%0d_nar", n), 64'(nar), 64'(miss));
            chk($sformatf("r%0d_proto", n), 64'(ok), 64'd1);
            if (miss) begin
                if (rr[1] || inv_r) m_vld = 0;
                else begin
                    m_vld = 1;
                    m_tag = line_of(id);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
